array_mem_unit: RTL and testbench

ARRAY_MEM_UNIT -- requirements
Module: array_mem_unit

---
 rtl/array_mem_unit_pkg.sv | 30 +++
 rtl/array_mem_unit_mem_ram.sv | 26 ++
 rtl/array_mem_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_array_mem_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_mem_unit_pkg.sv
// BusTypes: shared request bus, command mode and FSM state types for
// array_mem_unit and its users.
//   mem_mode_t   : READ / WRITE / ALLOC / FREE command encoding
//   mem_in_bus_t : request payload {data, address (array id), offset, mode}
//   amu_state_t  : array_mem_unit controller states
package BusTypes;

  typedef enum logic [1:0] {
    MEM_READ  = 2'b00,
    MEM_WRITE = 2'b01,
    MEM_ALLOC = 2'b10,
    MEM_FREE  = 2'b11
  } mem_mode_t;

  typedef struct packed {
    logic [31:0] data;     // write data, or requested size for ALLOC
    logic [15:0] address;  // array id
    logic [31:0] offset;   // word offset inside the array
    mem_mode_t   mode;
  } mem_in_bus_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ACCESS,
    ZERO_FILL,
    RESP
  } amu_state_t;

endpackage

// File: rtl/array_mem_unit_mem_ram.sv
// mem_ram: single-port synchronous-read RAM, DEPTH x 32 bits.
//   clk   : rising-edge clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (old contents on a write cycle)
module mem_ram #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/array_mem_unit.sv
// array_mem_unit: array-based memory manager over a single RAM.
// Keeps a table of NARRAYS arrays {base, size, live} allocated with a bump
// pointer, and serves read / write / alloc / free requests one at a time.
//   clk        : rising-edge clock
//   init_n     : asynchronous active-low reset
//   req        : request {data, address (array id), offset, mode}
//   req_valid  : request present; accepted when req_ready is high
//   req_ready  : controller idle
//   resp_data  : read data or newly allocated id (0 on error)
//   resp_valid : one-cycle response strobe
//   resp_err   : error qualifier for resp_valid
module array_mem_unit
  import BusTypes::*;
#(
  parameter int DEPTH      = 4096,
  parameter int NARRAYS    = 16,
  parameter int PROG_WORDS = 256
) (
  input  logic        clk,
  input  logic        init_n,
  input  mem_in_bus_t req,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [31:0] resp_data,
  output logic        resp_valid,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = AW + 1;
  localparam int IW = (NARRAYS > 1) ? $clog2(NARRAYS) : 1;

  amu_state_t         state_q, state_d;
  mem_in_bus_t        req_q, req_d;
  logic               err_q, err_d;
  logic [IW-1:0]      alloc_id_q, alloc_id_d;
  logic [AW-1:0]      fill_addr_q, fill_addr_d;
  logic [TW-1:0]      fill_cnt_q, fill_cnt_d;
  logic [TW-1:0]      top_q, top_d;
  logic [TW-1:0]      base_q [NARRAYS];
  logic [TW-1:0]      base_d [NARRAYS];
  logic [TW-1:0]      size_q [NARRAYS];
  logic [TW-1:0]      size_d [NARRAYS];
  logic [NARRAYS-1:0] live_q, live_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        resp_data_q, resp_data_d;

  logic               ram_we;
  logic [AW-1:0]      ram_addr;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;

  logic [IW-1:0]      id;
  logic               id_ok;
  logic [TW-1:0]      base_sel, size_sel;
  logic [AW-1:0]      acc_addr;
  logic [32:0]        alloc_end;
  logic [IW-1:0]      free_id;
  logic               free_found;
  logic               chk_err;

  // Decode of the captured request against the table
  assign id        = req_q.address[IW-1:0];
  assign id_ok     = (32'(req_q.address) < NARRAYS) && live_q[id];
  assign base_sel  = base_q[id];
  assign size_sel  = size_q[id];
  assign acc_addr  = base_sel[AW-1:0] + req_q.offset[AW-1:0];
  assign alloc_end = 33'(top_q) + {1'b0, req_q.data};

  // Lowest non-live id in 1..NARRAYS-1; id 0 is never handed out
  always_comb begin
    free_id    = '0;
    free_found = 1'b0;
    for (int i = NARRAYS - 1; i >= 1; i--) begin
      if (!live_q[i]) begin
        free_id    = IW'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    chk_err = 1'b0;
    case (req_q.mode)
      MEM_READ, MEM_WRITE: chk_err = !id_ok || (req_q.offset >= 32'(size_sel));
      MEM_ALLOC:           chk_err = !free_found || (alloc_end > 33'(DEPTH));
      MEM_FREE:            chk_err = !id_ok || (req_q.address == '0);
      default:             chk_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    err_d        = err_q;
    alloc_id_d   = alloc_id_q;
    fill_addr_d  = fill_addr_q;
    fill_cnt_d   = fill_cnt_q;
    top_d        = top_q;
    base_d       = base_q;
    size_d       = size_q;
    live_d       = live_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = resp_data_q;
    ram_we       = 1'b0;
    ram_addr     = acc_addr;
    ram_wdata    = req_q.data;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = req;
          state_d = CHECK;
        end
      end

      // Validate and commit. The RAM port is driven here so the synchronous
      // read returns during ACCESS; a write lands on the same edge.
      CHECK: begin
        err_d   = chk_err;
        state_d = ACCESS;
        if (!chk_err) begin
          case (req_q.mode)
            MEM_WRITE: ram_we = 1'b1;
            MEM_ALLOC: begin
              alloc_id_d      = free_id;
              base_d[free_id] = top_q;
              size_d[free_id] = req_q.data[TW-1:0];
              live_d[free_id] = 1'b1;
              top_d           = top_q + req_q.data[TW-1:0];
              fill_addr_d     = top_q[AW-1:0];
              fill_cnt_d      = req_q.data[TW-1:0];
            end
            MEM_FREE: begin
              live_d[id] = 1'b0;
              if (({1'b0, base_sel} + {1'b0, size_sel}) == {1'b0, top_q}) begin
                top_d = base_sel;
              end
            end
            default: ;
          endcase
        end
      end

      // Every command passes through ACCESS, so all non-filling commands
      // (including errors) share one latency.
      ACCESS: begin
        if (!err_q && (req_q.mode == MEM_ALLOC) && (fill_cnt_q != '0)) begin
          state_d = ZERO_FILL;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
          if (err_q) begin
            resp_data_d = '0;
          end else if (req_q.mode == MEM_READ) begin
            resp_data_d = ram_rdata;
          end else if (req_q.mode == MEM_ALLOC) begin
            resp_data_d = 32'(alloc_id_q);
          end else begin
            resp_data_d = '0;
          end
        end
      end

      ZERO_FILL: begin
        ram_we      = 1'b1;
        ram_addr    = fill_addr_q;
        ram_wdata   = '0;
        fill_addr_d = fill_addr_q + 1'b1;
        fill_cnt_d  = fill_cnt_q - 1'b1;
        if (fill_cnt_q == TW'(1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = 32'(alloc_id_q);
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q      <= IDLE;
      err_q        <= 1'b0;
      fill_cnt_q   <= '0;
      top_q        <= TW'(PROG_WORDS);
      live_q       <= NARRAYS'(1);
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      for (int i = 0; i < NARRAYS; i++) begin
        base_q[i] <= '0;
        size_q[i] <= (i == 0) ? TW'(PROG_WORDS) : '0;
      end
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      fill_cnt_q   <= fill_cnt_d;
      top_q        <= top_d;
      live_q       <= live_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      base_q       <= base_d;
      size_q       <= size_d;
    end
  end

  // Payload registers: only meaningful while a command is in flight
  always_ff @(posedge clk) begin
    req_q       <= req_d;
    alloc_id_q  <= alloc_id_d;
    fill_addr_q <= fill_addr_d;
  end

  mem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_array_mem_unit.sv
// Self-checking bench for array_mem_unit: directed scenarios plus randomized
// commands compared against a table/array model of the array manager.
module tb_array_mem_unit;
  import BusTypes::*;

  localparam int DEPTH      = 4096;
  localparam int NARRAYS    = 16;
  localparam int PROG_WORDS = 256;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  mem_in_bus_t req;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        resp_err;

  always #5 clk = ~clk;

  array_mem_unit #(.DEPTH(DEPTH), .NARRAYS(NARRAYS), .PROG_WORDS(PROG_WORDS)) dut (
    .clk(clk), .init_n(init_n), .req(req), .req_valid(req_valid),
    .req_ready(req_ready), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_err(resp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: array table, bump pointer and memory image
  int unsigned m_base [NARRAYS];
  int unsigned m_size [NARRAYS];
  bit          m_live [NARRAYS];
  int unsigned m_top;
  logic [31:0] mm [DEPTH];
  bit          mk [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NARRAYS; i++) begin
      m_live[i] = 0;
      m_base[i] = 0;
      m_size[i] = 0;
    end
    m_live[0] = 1;
    m_size[0] = PROG_WORDS;
    m_top     = PROG_WORDS;
  endtask

  task automatic model_op(input int mode, input int id, input int unsigned off,
                          input int unsigned data, output logic [31:0] ed,
                          output bit ee, output int el, output bit dknown);
    int a;
    int nid;
    ed = 0; ee = 0; el = 3; dknown = 0;
    case (mode)
      0, 1: begin
        if (id >= NARRAYS || !m_live[id] || off >= m_size[id]) ee = 1;
        else begin
          a = int'((m_base[id] + off) % DEPTH);
          if (mode == 1) begin
            mm[a] = data;
            mk[a] = 1;
          end else begin
            ed = mm[a];
            dknown = mk[a];
          end
        end
      end
      2: begin
        nid = -1;
        for (int i = NARRAYS - 1; i >= 1; i--) if (!m_live[i]) nid = i;
        if (nid < 0 || longint'(m_top) + longint'(data) > longint'(DEPTH)) ee = 1;
        else begin
          m_live[nid] = 1;
          m_base[nid] = m_top;
          m_size[nid] = data;
          for (int unsigned k = 0; k < data; k++) begin
            mm[(m_top + k) % DEPTH] = 0;
            mk[(m_top + k) % DEPTH] = 1;
          end
          m_top  = m_top + data;
          ed     = nid;
          dknown = 1;
          el     = 3 + int'(data);
        end
      end
      default: begin
        if (id >= NARRAYS || id == 0 || !m_live[id]) ee = 1;
        else begin
          m_live[id] = 0;
          if (m_base[id] + m_size[id] == m_top) m_top = m_base[id];
        end
      end
    endcase
    if (ee) dknown = 1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) check("ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic issue(input int mode, input int id, input int unsigned off,
                       input int unsigned data, output logic [31:0] gd,
                       output logic ge, output int lat);
    logic [1:0] m2;
    wait_ready();
    m2 = mode[1:0];
    req.mode    = mem_mode_t'(m2);
    req.address = 16'(id);
    req.offset  = off;
    req.data    = data;
    req_valid   = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; gd = '0; ge = 1'b0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (resp_valid) begin
        gd = resp_data;
        ge = resp_err;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input int mode, input int id,
                     input int unsigned off, input int unsigned data);
    logic [31:0] ed, gd;
    bit ee, dk;
    logic ge;
    int el, lat;
    model_op(mode, id, off, data, ed, ee, el, dk);
    issue(mode, id, off, data, gd, ge, lat);
    check({tag, "_lat"}, lat, el);
    check({tag, "_err"}, {31'b0, ge}, {31'b0, ee});
    if (dk) check({tag, "_data"}, gd, ed);
  endtask

  initial begin
    int nresp;
    logic [31:0] got;
    req       = '0;
    req_valid = 1'b0;
    m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mk[i] = 0;
      mm[i] = '0;
    end

    // Reset state while init_n is low
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    check("rst_data", resp_data, 32'd0);
    @(negedge clk) init_n = 1'b1;
    @(posedge clk); #1;
    check("rst_top", 32'(dut.top_q), 32'd256);
    check("rst_live", {16'b0, dut.live_q}, 32'h1);

    // Write then read id0 offset 5
    run("wr_id0", 1, 0, 5, 32'hDEADBEEF);
    run("rd_id0", 0, 0, 5, 0);

    // Alloc 4 -> id1, zero-filled
    run("alloc4", 2, 0, 0, 4);
    for (int k = 0; k < 4; k++) run($sformatf("rd_id1_%0d", k), 0, 1, k, 0);
    check("top_260", 32'(dut.top_q), 32'd260);

    // Errors: out-of-range offset, non-live id
    run("rd_id1_oob", 0, 1, 4, 0);
    run("rd_id9", 0, 9, 0, 0);

    // Allocation / free ordering and top reclamation
    run("alloc2", 2, 0, 0, 2);
    check("top_262a", 32'(dut.top_q), 32'd262);
    run("free1a", 3, 1, 0, 0);
    check("top_262b", 32'(dut.top_q), 32'd262);
    run("alloc3", 2, 0, 0, 3);
    check("base1_262", 32'(dut.base_q[1]), 32'd262);
    check("top_265", 32'(dut.top_q), 32'd265);
    run("free1b", 3, 1, 0, 0);
    check("top_262c", 32'(dut.top_q), 32'd262);
    run("free2", 3, 2, 0, 0);
    check("top_260b", 32'(dut.top_q), 32'd260);

    // Free of id0 and an oversize alloc are rejected
    run("free0", 3, 0, 0, 0);
    run("alloc_depth", 2, 0, 0, DEPTH);
    check("top_after_err", 32'(dut.top_q), 32'd260);

    // req_valid held through a busy command: the changed request is ignored
    wait_ready();
    req.mode = MEM_READ; req.address = 16'd0; req.offset = 32'd5; req.data = 32'd0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req.mode = MEM_WRITE; req.data = 32'h12345678;
    nresp = 0; got = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        nresp++;
        got = resp_data;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("busy_nresp", nresp, 32'd1);
    check("busy_data", got, 32'hDEADBEEF);
    run("busy_reread", 0, 0, 5, 0);

    // Randomized commands against the model
    for (int t = 0; t < 150; t++) begin
      int mode, id;
      int unsigned off, data;
      mode = int'($urandom_range(0, 3));
      id   = int'($urandom_range(0, NARRAYS + 1));
      off  = (id < NARRAYS) ? $urandom_range(0, m_size[id] + 1) : $urandom_range(0, 8);
      data = (mode == 2) ? (($urandom_range(0, 19) == 0) ? DEPTH : $urandom_range(0, 12)) : $urandom;
      run($sformatf("rnd%0d_m%0d", t, mode), mode, id, off, data);
    end

    // Reset pulsed during the zero fill of alloc 100
    @(negedge clk) init_n = 1'b0;
    @(negedge clk) init_n = 1'b1;
    m_reset();
    wait_ready();
    req.mode = MEM_ALLOC; req.address = 16'd0; req.offset = 32'd0; req.data = 32'd100;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nresp = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid) nresp++;
    end
    @(negedge clk) init_n = 1'b0;
    @(posedge clk); #1;
    check("zf_rst_ready", {31'b0, req_ready}, 32'd1);
    check("zf_rst_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk) init_n = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (resp_valid) nresp++;
    end
    check("zf_nresp", nresp, 32'd0);
    check("zf_live1", {31'b0, dut.live_q[1]}, 32'd0);
    check("zf_top", 32'(dut.top_q), 32'd256);
    for (int k = 256; k < 356; k++) mk[k] = 0;
    run("post_alloc3", 2, 0, 0, 3);
    check("post_base1", 32'(dut.base_q[1]), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
